// File: rtl/timer_pkg.sv
// Shared types for the multi-channel down-counter timer bank.
package timer_pkg;

    typedef enum logic {
        TIMER_ONESHOT  = 1'b0,
        TIMER_PERIODIC = 1'b1
    } timer_mode_e;

    typedef enum logic {
        TIMER_IDLE = 1'b0,
        TIMER_RUN  = 1'b1
    } timer_state_e;

endpackage

// File: rtl/timer_bank_ch.sv
// One timer channel: IDLE/RUN FSM, down-counter, reload value and registered done pulse.
module timer_ch
    import timer_pkg::*;
#(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_cnt,
    input  logic                 load_mode,
    input  logic                 stop,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] cnt
);

    timer_state_e          state, state_nxt;
    timer_mode_e           mode_q, mode_nxt;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_nxt;
    logic [CNT_WIDTH-1:0]  reload_q, reload_nxt;
    logic                  done_q, done_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= TIMER_IDLE;
            mode_q   <= TIMER_ONESHOT;
            cnt_q    <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            mode_q   <= mode_nxt;
            cnt_q    <= cnt_nxt;
            reload_q <= reload_nxt;
            done_q   <= done_nxt;
        end
    end

    // Load beats stop beats terminal; both load and stop swallow a pending expiry.
    always_comb begin
        state_nxt  = state;
        mode_nxt   = mode_q;
        cnt_nxt    = cnt_q;
        reload_nxt = reload_q;
        done_nxt   = 1'b0;
        if (load) begin
            state_nxt  = TIMER_RUN;
            cnt_nxt    = load_cnt;
            reload_nxt = load_cnt;
            mode_nxt   = timer_mode_e'(load_mode);
        end else if (state == TIMER_RUN) begin
            if (stop) begin
                state_nxt = TIMER_IDLE;
                cnt_nxt   = '0;
            end else if (cnt_q <= CNT_WIDTH'(1)) begin
                done_nxt = 1'b1;
                if (mode_q == TIMER_PERIODIC) begin
                    cnt_nxt = reload_q;
                end else begin
                    cnt_nxt   = '0;
                    state_nxt = TIMER_IDLE;
                end
            end else begin
                cnt_nxt = cnt_q - CNT_WIDTH'(1);
            end
        end
    end

    assign busy = (state == TIMER_RUN);
    assign done = done_q;
    assign cnt  = cnt_q;

endmodule

// File: rtl/timer_bank.sv
// NUM_CH independent programmable down-counters behind one shared config port.
module timer_bank
    import timer_pkg::*;
#(
    parameter int CNT_WIDTH = 8,
    parameter int NUM_CH    = 4,
    parameter int CH_IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                             i_clk,
    input  logic                             i_rst_sync,
    input  logic                             i_cfg_update,
    input  logic [CH_IDX_W-1:0]              i_cfg_ch,
    input  logic [CNT_WIDTH-1:0]             i_cfg_cnt,
    input  logic                             i_cfg_mode,
    input  logic [NUM_CH-1:0]                i_stop,
    output logic [NUM_CH-1:0]                o_busy,
    output logic [NUM_CH-1:0]                o_done,
    output logic                             o_any_done,
    output logic [NUM_CH-1:0][CNT_WIDTH-1:0] o_cnt,
    output logic                             o_cfg_err
);

    localparam logic [CH_IDX_W:0] NUM_CH_W = (CH_IDX_W + 1)'(NUM_CH);

    logic              cfg_valid;
    logic [NUM_CH-1:0] load;

    // Extra index bit lets non-power-of-two banks reject the unused codes.
    always_comb begin
        cfg_valid = i_cfg_update && ({1'b0, i_cfg_ch} < NUM_CH_W) && (i_cfg_cnt != '0);
        for (int k = 0; k < NUM_CH; k++) begin
            load[k] = cfg_valid && (i_cfg_ch == CH_IDX_W'(k));
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst_sync) o_cfg_err <= 1'b0;
        else            o_cfg_err <= i_cfg_update && !cfg_valid;
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        timer_ch #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_ch (
            .clk       (i_clk),
            .rst       (i_rst_sync),
            .load      (load[k]),
            .load_cnt  (i_cfg_cnt),
            .load_mode (i_cfg_mode),
            .stop      (i_stop[k]),
            .busy      (o_busy[k]),
            .done      (o_done[k]),
            .cnt       (o_cnt[k])
        );
    end

    assign o_any_done = |o_done;

endmodule

// File: tb/tb_timer_bank.sv
// Scoreboard bench for timer_bank: a 4-channel build plus a 3-channel build for index rejection.
module tb_timer_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, upd, upd3, mode;
    logic [1:0]      ch;
    logic [7:0]      ncnt;
    logic [3:0]      stop;
    logic [2:0]      stop3;
    logic [3:0]      busy, done;
    logic            any, err;
    logic [3:0][7:0] cnt;
    logic [2:0]      busy3, done3;
    logic            any3, err3;
    logic [2:0][7:0] cnt3;

    typedef struct {
        logic [3:0]      busy;
        logic [3:0]      done;
        logic [3:0][7:0] cnt;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;

    timer_bank #(.CNT_WIDTH(8), .NUM_CH(4)) dut (
        .i_clk(clk), .i_rst_sync(rst), .i_cfg_update(upd), .i_cfg_ch(ch),
        .i_cfg_cnt(ncnt), .i_cfg_mode(mode), .i_stop(stop),
        .o_busy(busy), .o_done(done), .o_any_done(any), .o_cnt(cnt), .o_cfg_err(err)
    );

    timer_bank #(.CNT_WIDTH(8), .NUM_CH(3)) dut3 (
        .i_clk(clk), .i_rst_sync(rst), .i_cfg_update(upd3), .i_cfg_ch(ch),
        .i_cfg_cnt(ncnt), .i_cfg_mode(mode), .i_stop(stop3),
        .o_busy(busy3), .o_done(done3), .o_any_done(any3), .o_cnt(cnt3), .o_cfg_err(err3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [1:0] c, input logic [7:0] n, input logic m);
        upd = 1'b1; ch = c; ncnt = n; mode = m;
        step();
        upd = 1'b0;
    endtask

    task automatic push(input logic [3:0] b, input logic [3:0] d, input logic [3:0][7:0] c);
        exp_t e;
        e.busy = b; e.done = d; e.cnt = c;
        sbq.push_back(e);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        checks++;
        if ({busy, done, any, cnt, err} !== '0) begin
            failures++;
            $display("FAIL reset_hold busy=%b done=%b any=%b cnt=%h err=%b want all 0", busy, done, any, cnt, err);
        end
        rst = 1'b0;
        step();
        checks++;
        if ({busy3, done3, any3, cnt3, err3, busy, done, cnt, err} !== '0) begin
            failures++;
            $display("FAIL reset_release busy=%b busy3=%b cnt=%h err3=%b want all 0", busy, busy3, cnt, err3);
        end
    endtask

    task automatic test_oneshot();
        exp_t e;
        for (int i = 0; i <= 6; i++)
            push((i < 5) ? 4'b0001 : 4'b0000, (i == 5) ? 4'b0001 : 4'b0000,
                 {24'h0, (i < 5) ? 8'(5 - i) : 8'd0});
        cfg(2'd0, 8'd5, 1'b0);
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            if ({busy, done, any, cnt} !== {e.busy, e.done, |e.done, e.cnt}) begin
                failures++;
                $display("FAIL oneshot busy=%b done=%b any=%b cnt=%h want busy=%b done=%b cnt=%h",
                         busy, done, any, cnt, e.busy, e.done, e.cnt);
            end
            step();
        end
    endtask

    task automatic test_periodic();
        exp_t e;
        for (int k = 0; k <= 12; k++)
            push(4'b0100, (k > 0 && k % 3 == 0) ? 4'b0100 : 4'b0000,
                 {8'd0, 8'(3 - k % 3), 16'h0});
        cfg(2'd2, 8'd3, 1'b1);
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            if ({busy, done, any, cnt} !== {e.busy, e.done, |e.done, e.cnt}) begin
                failures++;
                $display("FAIL periodic3 busy=%b done=%b cnt=%h want busy=%b done=%b cnt=%h",
                         busy, done, cnt, e.busy, e.done, e.cnt);
            end
            step();
        end
        for (int k = 0; k <= 4; k++)
            push(4'b0100, (k > 0) ? 4'b0100 : 4'b0000, {8'd0, 8'd1, 16'h0});
        cfg(2'd2, 8'd1, 1'b1);
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            if ({busy, done, any, cnt} !== {e.busy, e.done, |e.done, e.cnt}) begin
                failures++;
                $display("FAIL periodic1 busy=%b done=%b cnt=%h want busy=%b done=%b cnt=%h",
                         busy, done, cnt, e.busy, e.done, e.cnt);
            end
            step();
        end
        stop = 4'b0100;
        step();
        stop = 4'b0000;
        checks++;
        if ({busy, done, cnt} !== '0) begin
            failures++;
            $display("FAIL periodic_stop busy=%b done=%b cnt=%h want all 0", busy, done, cnt);
        end
    endtask

    task automatic test_cfg_err();
        cfg(2'd3, 8'd200, 1'b0);
        upd = 1'b1; ch = 2'd3; ncnt = 8'd0;
        step();
        upd = 1'b0;
        checks++;
        if ({err, busy, cnt[3]} !== {1'b1, 4'b1000, 8'd199}) begin
            failures++;
            $display("FAIL cfg_err_zero err=%b busy=%b cnt3=%0d want err=1 busy=1000 cnt3=199", err, busy, cnt[3]);
        end
        step();
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL cfg_err_clear err=%b want 0", err);
        end
        upd3 = 1'b1; ch = 2'd3; ncnt = 8'd5;
        step();
        upd3 = 1'b0;
        checks++;
        if ({err3, busy3, err} !== {1'b1, 3'b000, 1'b0}) begin
            failures++;
            $display("FAIL cfg_err_index err3=%b busy3=%b err=%b want err3=1 busy3=000 err=0", err3, busy3, err);
        end
        upd3 = 1'b1; ch = 2'd2; ncnt = 8'd5;
        step();
        upd3 = 1'b0;
        checks++;
        if ({err3, busy3, cnt3[2]} !== {1'b0, 3'b100, 8'd5}) begin
            failures++;
            $display("FAIL cfg_valid_ch2 err3=%b busy3=%b cnt=%0d want err3=0 busy3=100 cnt=5", err3, busy3, cnt3[2]);
        end
        stop = 4'hf; stop3 = 3'h7;
        step();
        stop = 4'h0; stop3 = 3'h0;
    endtask

    task automatic test_restart();
        exp_t e;
        for (int k = 0; k < 3; k++)
            push(4'b0010, 4'b0000, {16'h0, 8'(4 - k), 8'h0});
        cfg(2'd1, 8'd4, 1'b0);
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            if ({busy, done, cnt} !== {e.busy, e.done, e.cnt}) begin
                failures++;
                $display("FAIL restart_first busy=%b done=%b cnt=%h want busy=%b done=%b cnt=%h",
                         busy, done, cnt, e.busy, e.done, e.cnt);
            end
            step();
        end
        for (int k = 0; k <= 7; k++)
            push((k < 6) ? 4'b0010 : 4'b0000, (k == 6) ? 4'b0010 : 4'b0000,
                 {16'h0, (k < 6) ? 8'(6 - k) : 8'd0, 8'h0});
        cfg(2'd1, 8'd6, 1'b0);
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            if ({busy, done, any, cnt} !== {e.busy, e.done, |e.done, e.cnt}) begin
                failures++;
                $display("FAIL restart_second busy=%b done=%b cnt=%h want busy=%b done=%b cnt=%h",
                         busy, done, cnt, e.busy, e.done, e.cnt);
            end
            step();
        end
    endtask

    task automatic test_stop();
        exp_t e;
        for (int k = 0; k < 3; k++)
            push(4'b0001, 4'b0000, {24'h0, 8'(5 - k)});
        cfg(2'd0, 8'd5, 1'b0);
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            if ({busy, done, cnt} !== {e.busy, e.done, e.cnt}) begin
                failures++;
                $display("FAIL stop_run busy=%b done=%b cnt=%h want busy=%b done=%b cnt=%h",
                         busy, done, cnt, e.busy, e.done, e.cnt);
            end
            step();
        end
        stop = 4'b0001;
        step();
        stop = 4'b0000;
        checks++;
        if ({busy, done, cnt} !== '0) begin
            failures++;
            $display("FAIL stop_mid busy=%b done=%b cnt=%h want all 0", busy, done, cnt);
        end
        for (int k = 0; k < 2; k++)
            push(4'b0001, 4'b0000, {24'h0, 8'(3 - k)});
        cfg(2'd0, 8'd3, 1'b0);
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            if ({busy, done, cnt} !== {e.busy, e.done, e.cnt}) begin
                failures++;
                $display("FAIL stop_term_run busy=%b done=%b cnt=%h want busy=%b done=%b cnt=%h",
                         busy, done, cnt, e.busy, e.done, e.cnt);
            end
            step();
        end
        stop = 4'b0001;
        step();
        stop = 4'b0000;
        checks++;
        if ({busy, done, any, cnt} !== '0) begin
            failures++;
            $display("FAIL stop_terminal busy=%b done=%b any=%b cnt=%h want all 0", busy, done, any, cnt);
        end
        step();
        checks++;
        if (done !== 4'b0000) begin
            failures++;
            $display("FAIL stop_late_done done=%b want 0000", done);
        end
        for (int k = 0; k <= 5; k++)
            push((k < 4) ? 4'b0001 : 4'b0000, (k == 4) ? 4'b0001 : 4'b0000,
                 {24'h0, (k < 4) ? 8'(4 - k) : 8'd0});
        stop = 4'b0001;
        cfg(2'd0, 8'd4, 1'b0);
        stop = 4'b0000;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            if ({busy, done, cnt} !== {e.busy, e.done, e.cnt}) begin
                failures++;
                $display("FAIL update_over_stop busy=%b done=%b cnt=%h want busy=%b done=%b cnt=%h",
                         busy, done, cnt, e.busy, e.done, e.cnt);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   arm[4] = '{3, 0, 1, 2};
        int   per[4] = '{3, 3, 5, 7};
        int   coincide = 0;
        logic [3:0]      d;
        logic [3:0][7:0] c;
        for (int t = 3; t <= 14; t++) begin
            for (int k = 0; k < 4; k++) begin
                d[k] = (t > arm[k]) && ((t - arm[k]) % per[k] == 0);
                c[k] = 8'(per[k] - (t - arm[k]) % per[k]);
            end
            push(4'hf, d, c);
        end
        cfg(2'd1, 8'd3, 1'b1);
        cfg(2'd2, 8'd5, 1'b1);
        cfg(2'd3, 8'd7, 1'b1);
        cfg(2'd0, 8'd3, 1'b1);
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            if (done[0] && done[1] && any) coincide++;
            checks++;
            if ({busy, done, any, cnt} !== {e.busy, e.done, |e.done, e.cnt}) begin
                failures++;
                $display("FAIL multi busy=%b done=%b any=%b cnt=%h want busy=%b done=%b cnt=%h",
                         busy, done, any, cnt, e.busy, e.done, e.cnt);
            end
            step();
        end
        checks++;
        if (coincide !== 3) begin
            failures++;
            $display("FAIL multi_coincide count=%0d want 3", coincide);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({busy, done, any, cnt, err} !== '0) begin
            failures++;
            $display("FAIL midrun_reset busy=%b done=%b cnt=%h want all 0", busy, done, cnt);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if ({busy, done, any} !== '0) begin
                failures++;
                $display("FAIL post_reset busy=%b done=%b any=%b want all 0", busy, done, any);
            end
        end
    endtask

    initial begin
        rst = 1'b1; upd = 1'b0; upd3 = 1'b0; mode = 1'b0;
        ch = 2'd0; ncnt = 8'd0; stop = 4'h0; stop3 = 3'h0;
        test_reset();
        test_oneshot();
        test_periodic();
        test_cfg_err();
        test_restart();
        test_stop();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
